// File: rtl/pulse_edge_array.sv
// pulse_edge_array: per-channel synchronise -> qualify -> edge detect ->
// stretch to a PULSE_LEN-cycle pulse, plus a sticky per-channel event flag.
//
// Optional feature: define PULSE_EDGE_DEBOUNCE_EN to insert a per-channel
// debounce counter (DEBOUNCE_CYCLES) between the synchroniser and the
// edge detector. Without it, DEBOUNCE_CYCLES is ignored.
//
// Ports:
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   hold        [CHANNELS]    asynchronous level inputs
//   edge_mode   [2*CHANNELS]  per channel {fall_en, rise_en}; 00 = off
//   flag_clear  [CHANNELS]    synchronous clear of event_flag (set wins)
//   pulse       [CHANNELS]    registered stretched pulse
//   event_flag  [CHANNELS]    registered sticky event record
//   any_pulse                 registered OR of pulse
module pulse_edge_array #(
   parameter int unsigned CHANNELS        = 4,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned PULSE_LEN       = 1,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [CHANNELS-1:0]     hold,
   input  logic [2*CHANNELS-1:0]   edge_mode,
   input  logic [CHANNELS-1:0]     flag_clear,
   output logic [CHANNELS-1:0]     pulse,
   output logic [CHANNELS-1:0]     event_flag,
   output logic                    any_pulse
);

   localparam int unsigned CNT_W = $clog2(PULSE_LEN + 1);

   logic [SYNC_STAGES-1:0] sync_q     [CHANNELS];
   logic [CNT_W-1:0]       cnt_q      [CHANNELS];
   logic [CNT_W-1:0]       cnt_nxt_c  [CHANNELS];
   logic [CHANNELS-1:0]    sync_out_c;
   logic [CHANNELS-1:0]    stable_q;
   logic [CHANNELS-1:0]    stable_nxt_c;
   logic [CHANNELS-1:0]    prev_q;
   logic [CHANNELS-1:0]    rise_c;
   logic [CHANNELS-1:0]    fall_c;
   logic [CHANNELS-1:0]    event_c;
   logic [CHANNELS-1:0]    pulse_nxt_c;

   // Last synchroniser stage per channel
   always_comb begin
      sync_out_c = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         sync_out_c[i] = sync_q[i][SYNC_STAGES-1];
      end
   end

`ifdef PULSE_EDGE_DEBOUNCE_EN
   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [DB_W-1:0] db_q     [CHANNELS];
   logic [DB_W-1:0] db_nxt_c [CHANNELS];

   // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
   always_comb begin
      stable_nxt_c = stable_q;
      for (int i = 0; i < CHANNELS; i++) begin
         db_nxt_c[i] = '0;
         if (sync_out_c[i] != stable_q[i]) begin
            if (db_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               stable_nxt_c[i] = sync_out_c[i];
            end else begin
               db_nxt_c[i] = db_q[i] + DB_W'(1);
            end
         end
      end
   end

   // Debounce counters
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            db_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            db_q[i] <= db_nxt_c[i];
         end
      end
   end
`else
   // No qualification: the synchronised level is taken directly
   always_comb begin
      stable_nxt_c = sync_out_c;
   end
`endif

   assign rise_c = stable_q & ~prev_q;
   assign fall_c = ~stable_q & prev_q;

   // Edge select, pulse counter reload/decrement and next pulse state
   always_comb begin
      event_c     = '0;
      pulse_nxt_c = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         event_c[i] = (rise_c[i] & edge_mode[2*i]) | (fall_c[i] & edge_mode[2*i+1]);
         cnt_nxt_c[i] = cnt_q[i];
         if (event_c[i]) begin
            cnt_nxt_c[i] = CNT_W'(PULSE_LEN);
         end else if (cnt_q[i] != '0) begin
            cnt_nxt_c[i] = cnt_q[i] - CNT_W'(1);
         end
         pulse_nxt_c[i] = (cnt_nxt_c[i] != '0);
      end
   end

   // Main state: synchronisers, qualified/previous level, counters, outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            sync_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         stable_q   <= '0;
         prev_q     <= '0;
         pulse      <= '0;
         event_flag <= '0;
         any_pulse  <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], hold[i]};
            cnt_q[i]  <= cnt_nxt_c[i];
         end
         stable_q   <= stable_nxt_c;
         prev_q     <= stable_q;
         pulse      <= pulse_nxt_c;
         // Set has priority over a same-cycle clear
         event_flag <= (event_flag & ~flag_clear) | event_c;
         any_pulse  <= |pulse_nxt_c;
      end
   end

endmodule

// File: tb/tb_pulse_edge_array.sv
// Directed bench for pulse_edge_array (CHANNELS=4, SYNC_STAGES=2,
// PULSE_LEN=3, DEBOUNCE_CYCLES=4). Traces record pulse after each edge,
// bit k = value after edge k+1 counted from the first edge sampling a change.
module tb_pulse_edge_array;

   localparam int unsigned CH  = 4;
   localparam int unsigned SS  = 2;
   localparam int unsigned PL  = 3;
   localparam int unsigned DB  = 4;
`ifdef PULSE_EDGE_DEBOUNCE_EN
   localparam int unsigned LAT = SS + 1 + DB;
`else
   localparam int unsigned LAT = SS + 2;
`endif

   logic            clock;
   logic            reset_n;
   logic [CH-1:0]   hold;
   logic [2*CH-1:0] edge_mode;
   logic [CH-1:0]   flag_clear;
   logic [CH-1:0]   pulse;
   logic [CH-1:0]   event_flag;
   logic            any_pulse;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] tr;
   logic [31:0] at;
   logic [31:0] rise_mask;
   logic [31:0] fall_mask;

   pulse_edge_array #(
      .CHANNELS(CH), .SYNC_STAGES(SS), .PULSE_LEN(PL), .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clock(clock), .reset_n(reset_n), .hold(hold), .edge_mode(edge_mode),
      .flag_clear(flag_clear), .pulse(pulse), .event_flag(event_flag),
      .any_pulse(any_pulse)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      hold       = '0;
      edge_mode  = '0;
      flag_clear = '0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic set_mode(input int ch, input logic [1:0] m);
      edge_mode[2*ch +: 2] = m;
   endtask

   // Hold ch1 high for 10 edges then low; trace 24 edges
   task automatic run_hilo(input logic [1:0] m, input logic [31:0] exp, input string tag);
      do_reset();
      set_mode(1, m);
      hold[1] = 1'b1;
      tr = '0;
      at = '0;
      for (int k = 0; k < 24; k++) begin
         if (k == 10) hold[1] = 1'b0;
         step();
         tr[k] = pulse[1];
         at[k] = any_pulse;
      end
      check_eq({tag, "_pulse"}, tr, exp);
      check_eq({tag, "_any"}, at, exp);
   endtask

   initial begin
      rise_mask = 32'h7 << (LAT - 1);
      fall_mask = 32'h7 << (10 + LAT - 1);

      // Reset state
      do_reset();
      check_eq("rst_pulse", 32'(pulse), 32'h0);
      check_eq("rst_flag", 32'(event_flag), 32'h0);
      check_eq("rst_any", 32'(any_pulse), 32'h0);

      // Rising edge on ch0, 3-cycle pulse at edge LAT
      do_reset();
      set_mode(0, 2'b01);
      hold[0] = 1'b1;
      tr = '0;
      at = '0;
      for (int k = 0; k < 16; k++) begin
         step();
         tr[k] = pulse[0];
         at[k] = any_pulse;
      end
      check_eq("rise_pulse", tr, rise_mask);
      check_eq("rise_any", at, rise_mask);
      check_eq("rise_flag", 32'(event_flag), 32'h1);

      // Mode variants on ch1
      run_hilo(2'b11, rise_mask | fall_mask, "both");
      run_hilo(2'b10, fall_mask, "fall");
      run_hilo(2'b00, 32'h0, "off");

`ifndef PULSE_EDGE_DEBOUNCE_EN
      // Toggle ch2 every 2 cycles: retrigger keeps pulse high, edges 4..12
      do_reset();
      set_mode(2, 2'b11);
      hold[2] = 1'b1;
      tr = '0;
      for (int k = 0; k < 20; k++) begin
         if (k == 2 || k == 4 || k == 6) hold[2] = ~hold[2];
         step();
         tr[k] = pulse[2];
      end
      check_eq("retrig_pulse", tr, 32'h0000_0FF8);
`else
      // Glitch of 3 cycles is filtered
      do_reset();
      set_mode(0, 2'b01);
      hold[0] = 1'b1;
      tr = '0;
      for (int k = 0; k < 20; k++) begin
         if (k == 3) hold[0] = 1'b0;
         step();
         tr[k] = pulse[0];
      end
      check_eq("glitch3_pulse", tr, 32'h0);
      // 4 cycles is accepted, pulse from edge 7
      do_reset();
      set_mode(0, 2'b01);
      hold[0] = 1'b1;
      tr = '0;
      for (int k = 0; k < 20; k++) begin
         if (k == 4) hold[0] = 1'b0;
         step();
         tr[k] = pulse[0];
      end
      check_eq("glitch4_pulse", tr, 32'h0000_01C0);
`endif

      // Flag: same-cycle clear loses to set, later clear wins
      do_reset();
      set_mode(3, 2'b01);
      hold[3] = 1'b1;
      repeat (LAT - 1) step();
      flag_clear[3] = 1'b1;
      step();
      flag_clear[3] = 1'b0;
      check_eq("flag_set_wins", 32'(event_flag), 32'h8);
      check_eq("flag_ch3_pulse", 32'(pulse), 32'h8);
      step();
      step();
      check_eq("flag_sticky", 32'(event_flag), 32'h8);
      flag_clear[3] = 1'b1;
      step();
      flag_clear[3] = 1'b0;
      check_eq("flag_cleared", 32'(event_flag), 32'h0);

      // All channels at once
      do_reset();
      edge_mode = 8'b01_01_01_01;
      hold = 4'hF;
      repeat (LAT - 1) step();
      check_eq("all_pre", 32'(pulse), 32'h0);
      step();
      check_eq("all_pulse", 32'(pulse), 32'hF);
      check_eq("all_flag", 32'(event_flag), 32'hF);
      check_eq("all_any", 32'(any_pulse), 32'h1);

      // Mode off mid-pulse: pulse completes, later fall ignored
      do_reset();
      set_mode(0, 2'b11);
      hold[0] = 1'b1;
      tr = '0;
      for (int k = 0; k < 24; k++) begin
         if (k == int'(LAT)) set_mode(0, 2'b00);
         if (k == int'(LAT) + 2) hold[0] = 1'b0;
         step();
         tr[k] = pulse[0];
      end
      check_eq("modeoff_pulse", tr, rise_mask);

      // Asynchronous reset mid-pulse, then hold high gives one pulse
      do_reset();
      set_mode(0, 2'b01);
      hold[0] = 1'b1;
      repeat (LAT) step();
      check_eq("pre_rst_pulse", 32'(pulse), 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("async_rst_pulse", 32'(pulse), 32'h0);
      check_eq("async_rst_any", 32'(any_pulse), 32'h0);
      check_eq("async_rst_flag", 32'(event_flag), 32'h0);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      tr = '0;
      for (int k = 0; k < 16; k++) begin
         step();
         tr[k] = pulse[0];
      end
      check_eq("post_rst_pulse", tr, rise_mask);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pulse_edge_array.md
PULSE_EDGE_ARRAY -- requirements
Module: pulse_edge_array

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent input channels, 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel, 2..4.
REQ-003 Parameter PULSE_LEN, default 1: output pulse length in clock cycles, 1..255.
REQ-004 Parameter DEBOUNCE_CYCLES, default 4: consecutive differing cycles required before accepting a new level, 1..65535; used only with the macro in REQ-026.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 hold  input  CHANNELS  asynchronous level inputs, one bit per channel.
REQ-008 edge_mode  input  2*CHANNELS  per-channel edge select, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-009 flag_clear  input  CHANNELS  synchronous per-channel clear of event_flag.
REQ-010 pulse  output  CHANNELS  registered per-channel pulse output.
REQ-011 event_flag  output  CHANNELS  registered sticky per-channel event record.
REQ-012 any_pulse  output  1  registered OR of the next-state pulse vector; equals the OR of pulse every cycle.

Function
REQ-013 Synchroniser: hold[i] SHALL pass through SYNC_STAGES flops; sync_out[i] is the last stage.
REQ-014 Qualified level (macro absent): stable[i] <= sync_out[i] on every edge.
REQ-015 Edge detect: prev[i] <= stable[i] every edge; rise = stable & ~prev; fall = ~stable & prev.
REQ-016 event[i] = (rise & mode bit0) | (fall & mode bit1); edge_mode is sampled combinationally, so a change takes effect on the same cycle.
REQ-017 Pulse counter: on event[i], cnt[i] <= PULSE_LEN; else if cnt[i] > 0, cnt[i] decrements; pulse[i] <= 1 while the next-state cnt[i] is nonzero.
REQ-018 A retrigger during an active pulse reloads cnt[i] to PULSE_LEN; pulse stays high with no gap and the output is extended.
REQ-019 With PULSE_LEN=1, each event yields exactly one high cycle; back-to-back events yield a continuous high.
REQ-020 Latency (macro absent): pulse asserts on the (SYNC_STAGES+2)th rising edge after the first edge that samples the new hold level.
REQ-021 edge_mode=00 suppresses new events only; an active pulse SHALL still run to completion.
REQ-022 event_flag[i] is set on event[i] and cleared on flag_clear[i]; if both occur in the same cycle, set wins.
REQ-023 Channels are fully independent; a simultaneous event on every channel SHALL be handled in the same cycle.
REQ-024 Counter width is clog2(PULSE_LEN+1); no wrap is permitted.

Reset
REQ-025 While reset_n=0: all sync stages, stable, prev, counters, pulse, event_flag, any_pulse and debounce counters are 0, asynchronously. A hold input high at reset release produces a rising edge after synchronisation (stable resets to 0).

Configuration
REQ-026 Macro PULSE_EDGE_DEBOUNCE_EN defined: each channel has a debounce counter of clog2(DEBOUNCE_CYCLES+1) bits.
- The counter increments each cycle that sync_out != stable.
- It resets to 0 on any cycle where they are equal.
- When the counter equals DEBOUNCE_CYCLES-1 and sync_out still differs, stable <= sync_out and the counter resets to 0.
- Latency becomes SYNC_STAGES+1+DEBOUNCE_CYCLES edges.
- DEBOUNCE_CYCLES=1 SHALL behave identically to the macro-absent build.
REQ-027 Macro undefined: no debounce logic is instantiated, DEBOUNCE_CYCLES is ignored, and REQ-014 applies.

Verification (CHANNELS=4, SYNC_STAGES=2, PULSE_LEN=3, DEBOUNCE_CYCLES=4)
REQ-028 Mode 01 on ch0, hold[0] 0->1 held -> pulse[0] high for exactly 3 cycles starting on the 4th edge, event_flag[0]=1, any_pulse mirrors pulse[0].
REQ-029 Mode 11 on ch1, hold[1] high for 10 cycles then low -> two 3-cycle pulses 10 cycles apart; mode 10 -> only the second pulse; mode 00 -> none.
REQ-030 Mode 11 on ch2, hold[2] toggles every 2 cycles -> pulse[2] continuously high until 3 cycles after the last qualified edge (retrigger extension).
REQ-031 flag_clear[3] asserted in the same cycle as an event on ch3 -> event_flag[3] stays 1; a clear on a later cycle -> event_flag[3]=0.
REQ-032 Debounce build, hold[0] glitch high for 3 cycles -> no pulse; high for 4 cycles -> one pulse asserted 7 edges after first sampling.
REQ-033 reset_n driven low mid-pulse -> pulse, any_pulse and event_flag go 0 immediately without a clock; after release with hold held high -> one rising-edge pulse.
